// File: rtl/max_tracker.sv
// Running-maximum tracker that drives an external 2-bit comparator and decodes
// its result code to update the stored maximum, tie/update counters and a sticky error.
module max_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [1:0] in_data,
    output logic       in_ready,
    output logic [1:0] cmp_first,
    output logic [1:0] cmp_second,
    input  logic [1:0] cmp_out,
    output logic [1:0] max_out,
    output logic       max_valid,
    output logic [3:0] tie_count,
    output logic [3:0] upd_count,
    output logic       err
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_IDLE  = 2'd1,
        S_CMP   = 2'd2
    } state_t;

    localparam logic [1:0] CODE_EQUAL   = 2'b00;
    localparam logic [1:0] CODE_FIRST   = 2'b01;
    localparam logic [1:0] CODE_SECOND  = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    state_t     r_state;
    state_t     w_stateNext;

    logic [1:0] r_max;
    logic [1:0] r_sample;
    logic       r_maxValid;
    logic [3:0] r_tieCount;
    logic [3:0] r_updCount;
    logic       r_err;

    logic [1:0] w_maxNext;
    logic [1:0] w_sampleNext;
    logic       w_maxValidNext;
    logic [3:0] w_tieCountNext;
    logic [3:0] w_updCountNext;
    logic       w_errNext;

    logic       w_ready;
    logic       w_accept;
    logic [3:0] w_tieInc;
    logic [3:0] w_updInc;

    assign w_ready  = (r_state != S_CMP);
    assign w_accept = in_valid & w_ready;

    assign w_tieInc = (r_tieCount == 4'd15) ? r_tieCount : r_tieCount + 4'd1;
    assign w_updInc = (r_updCount == 4'd15) ? r_updCount : r_updCount + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Clear outranks both acceptance and the compare decode, so an in-flight result is dropped.
    always_comb begin
        w_stateNext    = r_state;
        w_maxNext      = r_max;
        w_sampleNext   = r_sample;
        w_maxValidNext = r_maxValid;
        w_tieCountNext = r_tieCount;
        w_updCountNext = r_updCount;
        w_errNext      = r_err;

        if (clear) begin
            w_stateNext    = S_EMPTY;
            w_maxNext      = 2'd0;
            w_sampleNext   = 2'd0;
            w_maxValidNext = 1'b0;
            w_tieCountNext = 4'd0;
            w_updCountNext = 4'd0;
            w_errNext      = 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_maxNext      = in_data;
                        w_maxValidNext = 1'b1;
                        w_stateNext    = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        w_sampleNext = in_data;
                        w_stateNext  = S_CMP;
                    end
                end
                S_CMP: begin
                    case (cmp_out)
                        CODE_EQUAL:   w_tieCountNext = w_tieInc;
                        CODE_FIRST: begin
                            w_maxNext      = r_sample;
                            w_updCountNext = w_updInc;
                        end
                        CODE_SECOND:  w_maxNext = r_max;
                        CODE_ILLEGAL: w_errNext = 1'b1;
                        default:      w_errNext = r_err;
                    endcase
                    w_stateNext = S_IDLE;
                end
                default: begin
                    w_stateNext = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_max      <= 2'd0;
            r_sample   <= 2'd0;
            r_maxValid <= 1'b0;
            r_tieCount <= 4'd0;
            r_updCount <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_max      <= w_maxNext;
            r_sample   <= w_sampleNext;
            r_maxValid <= w_maxValidNext;
            r_tieCount <= w_tieCountNext;
            r_updCount <= w_updCountNext;
            r_err      <= w_errNext;
        end
    end

    assign in_ready   = w_ready;
    assign cmp_first  = r_sample;
    assign cmp_second = r_max;
    assign max_out    = r_max;
    assign max_valid  = r_maxValid;
    assign tie_count  = r_tieCount;
    assign upd_count  = r_updCount;
    assign err        = r_err;

endmodule
